// File: rtl/vlc_block_unpacker_if.sv
// Stream bundle for the VLC block unpacker: packed-block input, symbol output, error report.
// The slave modport is the unpacker side; master is the producer/consumer side.
interface vlc_block_unpacker_if #(
    parameter int unsigned NSYM  = 64,
    parameter int unsigned BLK_W = 512,
    parameter int unsigned HDR_W = 4,
    parameter int unsigned MAX_L = 8
);
    localparam int unsigned IDX_W = $clog2(NSYM);
    localparam int unsigned NB_W  = $clog2(BLK_W / 8) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [BLK_W-1:0] in_data;
    logic [NB_W-1:0]  in_nbytes;
    logic             out_valid;
    logic             out_ready;
    logic [MAX_L-1:0] out_sym;
    logic [HDR_W-1:0] out_len;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             err_valid;
    logic [1:0]       err_code;

    modport master (
        output in_valid, in_data, in_nbytes, out_ready,
        input  in_ready, out_valid, out_sym, out_len, out_idx, out_last, err_valid, err_code
    );

    modport slave (
        input  in_valid, in_data, in_nbytes, out_ready,
        output in_ready, out_valid, out_sym, out_len, out_idx, out_last, err_valid, err_code
    );
endinterface

// File: rtl/vlc_block_unpacker.sv
// Unpacks a left-justified block of length-prefixed symbols, one symbol per output handshake,
// walking the block MSB-first with a shift register.
module vlc_block_unpacker #(
    parameter int unsigned NSYM  = 64,
    parameter int unsigned BLK_W = 512,
    parameter int unsigned HDR_W = 4,
    parameter int unsigned MAX_L = 8
) (
    input logic clk,
    input logic rst,
    vlc_block_unpacker_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NSYM);
    localparam int unsigned NB_W  = $clog2(BLK_W / 8) + 1;
    localparam int unsigned CNT_W = $clog2(BLK_W) + 1;

    typedef enum logic [1:0] {StIdle, StParse, StEmit, StErr} state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MAX_L-1:0] sym_q, sym_d;
    logic [HDR_W-1:0] len_q, len_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             last_q, last_d;
    logic [1:0]       err_code_q, err_code_d;

    logic [HDR_W-1:0] hdr;
    logic [MAX_L-1:0] payload_top;
    logic [CNT_W-1:0] step;
    logic [CNT_W-1:0] bits_rem;
    logic             nbytes_ok;

    assign hdr         = blk_q[BLK_W-1 -: HDR_W];
    assign payload_top = blk_q[BLK_W-HDR_W-1 -: MAX_L];
    assign step        = CNT_W'(len_q) + CNT_W'(HDR_W);
    assign bits_rem    = bits_left_q - step;
    assign nbytes_ok   = (bus.in_nbytes != '0) && (bus.in_nbytes <= NB_W'(BLK_W / 8));

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        bits_left_d = bits_left_q;
        idx_d       = idx_q;
        sym_d       = sym_q;
        len_d       = len_q;
        out_idx_d   = out_idx_q;
        last_d      = last_q;
        err_code_d  = err_code_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    blk_d       = bus.in_data;
                    bits_left_d = CNT_W'({bus.in_nbytes, 3'b000});
                    idx_d       = IDX_W'(NSYM - 1);
                    if (nbytes_ok) begin
                        state_d = StParse;
                    end else begin
                        state_d    = StErr;
                        err_code_d = 2'd2;
                    end
                end
            end
            StParse: begin
                if (hdr > HDR_W'(MAX_L)) begin
                    state_d    = StErr;
                    err_code_d = 2'd1;
                end else if (CNT_W'(hdr) + CNT_W'(HDR_W) > bits_left_q) begin
                    state_d    = StErr;
                    err_code_d = 2'd2;
                end else begin
                    // Right-align the top L payload bits; a shift of MAX_L yields zero for L=0.
                    sym_d     = payload_top >> (HDR_W'(MAX_L) - hdr);
                    len_d     = hdr;
                    out_idx_d = idx_q;
                    last_d    = (idx_q == '0);
                    state_d   = StEmit;
                end
            end
            StEmit: begin
                if (bus.out_ready) begin
                    blk_d       = blk_q << step;
                    bits_left_d = bits_rem;
                    last_d      = 1'b0;
                    if (idx_q == '0) begin
                        if (bits_rem >= CNT_W'(8)) begin
                            state_d    = StErr;
                            err_code_d = 2'd3;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = StParse;
                    end
                end
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            blk_q       <= '0;
            bits_left_q <= '0;
            idx_q       <= '0;
            sym_q       <= '0;
            len_q       <= '0;
            out_idx_q   <= '0;
            last_q      <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            blk_q       <= blk_d;
            bits_left_q <= bits_left_d;
            idx_q       <= idx_d;
            sym_q       <= sym_d;
            len_q       <= len_d;
            out_idx_q   <= out_idx_d;
            last_q      <= last_d;
            err_code_q  <= err_code_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StEmit);
    assign bus.out_sym   = sym_q;
    assign bus.out_len   = len_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = last_q;
    assign bus.err_valid = (state_q == StErr);
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_vlc_block_unpacker.sv
// Directed bench for vlc_block_unpacker: hand-built blocks, expected symbols per index.
module tb_vlc_block_unpacker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vlc_block_unpacker_if bus ();

    vlc_block_unpacker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int hs_cnt   = 0;
    int last_cnt = 0;
    int acc_cyc  = 0;

    logic [511:0] blk;
    int           pos;
    logic [7:0]   exp_sym [64];
    logic [3:0]   exp_len [64];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.err_valid === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            hs_cnt <= hs_cnt + 1;
            if (bus.out_last === 1'b1) last_cnt <= last_cnt + 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int len, input int payload);
        for (int b = 3; b >= 0; b--) begin
            blk[511-pos] = len[b];
            pos++;
        end
        for (int b = len - 1; b >= 0; b--) begin
            blk[511-pos] = payload[b];
            pos++;
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) begin
            exp_sym[i] = 8'h00;
            exp_len[i] = 4'h0;
        end
    endtask

    task automatic send(input logic [511:0] d, input logic [6:0] nb);
        check("in_ready_idle", 32'(bus.in_ready), 1);
        bus.in_data   = d;
        bus.in_nbytes = nb;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        acc_cyc       = cyc;
    endtask

    // Consumes n symbols with out_ready high, starting from first_idx downward.
    task automatic consume(input int n, input int first_idx);
        for (int k = 0; k < n; k++) begin
            int idx;
            int g;
            idx = first_idx - k;
            g   = 0;
            while (bus.out_valid !== 1'b1 && g < 20) begin
                tick();
                g++;
            end
            check("out_valid", 32'(bus.out_valid), 1);
            check("out_idx", 32'(bus.out_idx), 32'(idx));
            check("out_sym", 32'(bus.out_sym), 32'(exp_sym[idx]));
            check("out_len", 32'(bus.out_len), 32'(exp_len[idx]));
            check("out_last", 32'(bus.out_last), 32'(idx == 0));
            check("err_quiet", 32'(bus.err_valid), 0);
            tick();
        end
    endtask

    initial begin
        int e0;
        int l0;
        int h0;
        logic [7:0] s0;
        logic [3:0] n0;
        logic [5:0] i0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_nbytes = '0;
        bus.out_ready = 1'b1;
        clear_exp();

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_err_valid", 32'(bus.err_valid), 0);
        check("rst_err_code", 32'(bus.err_code), 0);
        check("rst_out_idx", 32'(bus.out_idx), 0);
        check("rst_out_sym", 32'(bus.out_sym), 0);
        check("rst_out_last", 32'(bus.out_last), 0);
        rst = 1'b0;
        tick();

        // All-zero headers, 32 bytes: 64 empty symbols, idle again 128 cycles after accept
        blk = '0;
        e0  = err_cnt;
        l0  = last_cnt;
        send(blk, 7'd32);
        check("t1_busy", 32'(bus.in_ready), 0);
        check("t1_not_yet_valid", 32'(bus.out_valid), 0);
        tick();
        check("t1_first_valid", 32'(bus.out_valid), 1);
        consume(64, 63);
        check("t1_latency", 32'(cyc - acc_cyc), 128);
        check("t1_idle", 32'(bus.in_ready), 1);
        check("t1_no_err", 32'(err_cnt - e0), 0);
        check("t1_one_last", 32'(last_cnt - l0), 1);

        // Mixed lengths: 8+0xA5, 3+3'b101, 62 empty (267 bits in 34 bytes)
        blk = '0;
        pos = 0;
        put(8, 'hA5);
        put(3, 'b101);
        exp_sym[63] = 8'hA5;
        exp_len[63] = 4'd8;
        exp_sym[62] = 8'h05;
        exp_len[62] = 4'd3;
        e0 = err_cnt;
        send(blk, 7'd34);
        consume(64, 63);
        check("t2_idle", 32'(bus.in_ready), 1);
        check("t2_no_err", 32'(err_cnt - e0), 0);
        clear_exp();

        // Illegal length header 9
        blk = '0;
        blk[511:508] = 4'd9;
        send(blk, 7'd64);
        check("t3_no_valid", 32'(bus.out_valid), 0);
        tick();
        check("t3_err_valid", 32'(bus.err_valid), 1);
        check("t3_err_code", 32'(bus.err_code), 1);
        check("t3_no_valid2", 32'(bus.out_valid), 0);
        tick();
        check("t3_in_ready", 32'(bus.in_ready), 1);
        check("t3_err_pulse", 32'(bus.err_valid), 0);
        check("t3_code_held", 32'(bus.err_code), 1);

        // Overrun: 31 bytes hold only 62 empty symbols
        blk = '0;
        l0  = last_cnt;
        send(blk, 7'd31);
        consume(62, 63);
        tick();
        check("t4a_err_valid", 32'(bus.err_valid), 1);
        check("t4a_err_code", 32'(bus.err_code), 2);
        check("t4a_no_valid", 32'(bus.out_valid), 0);
        check("t4a_no_last", 32'(last_cnt - l0), 0);
        tick();
        check("t4a_idle", 32'(bus.in_ready), 1);

        // Trailing data: 64 bytes leave 256 unused bits
        send(blk, 7'd64);
        consume(64, 63);
        check("t4b_err_valid", 32'(bus.err_valid), 1);
        check("t4b_err_code", 32'(bus.err_code), 3);
        tick();
        check("t4b_idle", 32'(bus.in_ready), 1);
        check("t4b_err_pulse", 32'(bus.err_valid), 0);

        // Zero-byte block is an overrun straight away
        send(blk, 7'd0);
        check("t4c_err_valid", 32'(bus.err_valid), 1);
        check("t4c_err_code", 32'(bus.err_code), 2);
        tick();
        check("t4c_idle", 32'(bus.in_ready), 1);

        // Backpressure on idx 62 of the mixed-length block
        blk = '0;
        pos = 0;
        put(8, 'hA5);
        put(3, 'b101);
        exp_sym[63] = 8'hA5;
        exp_len[63] = 4'd8;
        exp_sym[62] = 8'h05;
        exp_len[62] = 4'd3;
        h0 = hs_cnt;
        send(blk, 7'd34);
        consume(1, 63);
        bus.out_ready = 1'b0;
        tick();
        s0 = bus.out_sym;
        n0 = bus.out_len;
        i0 = bus.out_idx;
        check("t5_stall_idx", 32'(i0), 62);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5_hold_valid", 32'(bus.out_valid), 1);
            check("t5_hold_sym", 32'(bus.out_sym), 32'(s0));
            check("t5_hold_len", 32'(bus.out_len), 32'(n0));
            check("t5_hold_idx", 32'(bus.out_idx), 32'(i0));
        end
        bus.out_ready = 1'b1;
        consume(63, 62);
        check("t5_handshakes", 32'(hs_cnt - h0), 64);
        check("t5_idle", 32'(bus.in_ready), 1);

        // Reset after 10 symbols, then a fresh block decodes from idx 63
        blk = '0;
        clear_exp();
        send(blk, 7'd32);
        consume(10, 63);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_out_valid", 32'(bus.out_valid), 0);
        check("t6_in_ready", 32'(bus.in_ready), 1);
        check("t6_err_valid", 32'(bus.err_valid), 0);
        check("t6_out_last", 32'(bus.out_last), 0);
        tick();
        tick();
        check("t6_still_quiet", 32'(bus.out_valid), 0);
        blk = '0;
        pos = 0;
        put(8, 'hA5);
        put(3, 'b101);
        exp_sym[63] = 8'hA5;
        exp_len[63] = 4'd8;
        exp_sym[62] = 8'h05;
        exp_len[62] = 4'd3;
        e0 = err_cnt;
        send(blk, 7'd34);
        consume(64, 63);
        check("t6_idle", 32'(bus.in_ready), 1);
        check("t6_no_err", 32'(err_cnt - e0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
